// File: rtl/mmio_sys_ctrl.sv
// mmio_sys_ctrl: a system-control register window placed in front of data memory.
// It provides buffered byte-output channels, a sticky halt with exit code, and a
// 64-bit cycle counter. Every request outside the window goes to memory unchanged.

// Per-channel byte FIFO. If a pop happens in the same cycle as a push to a full
// FIFO, the pop frees the slot, so the push is accepted.
module mmio_sys_ctrl_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic       ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic          pop, acc;

    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign valid = !empty;
    assign dout  = mem[rptr];
    assign pop   = valid && ready;
    assign acc   = push && (!full || pop);

    // Storage array. It has no reset because the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (acc) mem[wptr] <= din;
    end

    // Pointers, occupancy, and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (acc) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (acc && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !acc) cnt <= cnt - 1'b1;
            if (push && !acc) ovf <= 1'b1;
        end
    end
endmodule

module mmio_sys_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h0002_FFE0,
    parameter int          NUM_CH     = 1,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req_valid,
    input  logic [31:0]           core_req_addr,
    input  logic [3:0]            core_req_do_read,
    input  logic [3:0]            core_req_do_write,
    input  logic [31:0]           core_req_data,
    output logic                  core_rsp_valid,
    output logic [31:0]           core_rsp_data,
    output logic                  mem_req_valid,
    output logic [31:0]           mem_req_addr,
    output logic [3:0]            mem_req_do_read,
    output logic [3:0]            mem_req_do_write,
    output logic [31:0]           mem_req_data,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rsp_data,
    output logic [NUM_CH-1:0]     tx_valid,
    output logic [8*NUM_CH-1:0]   tx_data,
    input  logic [NUM_CH-1:0]     tx_ready,
    output logic                  halt,
    output logic [7:0]            exit_code,
    output logic                  halt_done
);
    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_CLO    = 3'd1;
    localparam logic [2:0] OFF_CHI    = 3'd2;
    localparam logic [2:0] OFF_HALT   = 3'd7;

    logic              hit, win_rd, win_wr;
    logic [2:0]        off;
    logic [NUM_CH-1:0] push, full, empty, ovf;
    logic [31:0]       status, rdata;
    logic [63:0]       cycle;
    logic [31:0]       shadow;
    logic              rsp_pend;
    logic [31:0]       rsp_data;

    assign hit    = (core_req_addr[31:5] == BASE_ADDR[31:5]);
    assign off    = core_req_addr[4:2];
    assign win_rd = core_req_valid && hit && (|core_req_do_read);
    assign win_wr = core_req_valid && hit && (|core_req_do_write);

    // Requests outside the window go straight to memory. Window requests are never forwarded.
    assign mem_req_valid    = core_req_valid && !hit;
    assign mem_req_addr     = core_req_addr;
    assign mem_req_do_read  = core_req_do_read;
    assign mem_req_do_write = core_req_do_write;
    assign mem_req_data     = core_req_data;

    // A registered window response takes priority over the memory response path.
    assign core_rsp_valid = rsp_pend ? 1'b1 : mem_rsp_valid;
    assign core_rsp_data  = rsp_pend ? rsp_data : mem_rsp_data;

    assign halt_done = halt && (&empty);

    // One FIFO per channel. Channel c is written at word offset 6-c, counting down from 0x18.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign push[c] = win_wr && (off == 3'(6 - c));

        mmio_sys_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[c]),
            .din   (core_req_data[7:0]),
            .ready (tx_ready[c]),
            .valid (tx_valid[c]),
            .dout  (tx_data[8*c +: 8]),
            .full  (full[c]),
            .empty (empty[c]),
            .ovf   (ovf[c])
        );
    end

    // STATUS word, built from the flag values before this cycle's push and pop take effect.
    always_comb begin
        status = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            status[c]      = full[c];
            status[8 + c]  = empty[c];
            status[16 + c] = ovf[c];
        end
    end

    // Read mux. Write-only and unused offsets read as zero.
    always_comb begin
        rdata = '0;
        case (off)
            OFF_STATUS: rdata = status;
            OFF_CLO:    rdata = cycle[31:0];
            OFF_CHI:    rdata = shadow;
            default:    rdata = '0;
        endcase
    end

    // Window read response arrives one cycle after the request, matching memory latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_pend <= 1'b0;
            rsp_data <= '0;
        end else begin
            rsp_pend <= win_rd;
            if (win_rd) rsp_data <= rdata;
        end
    end

    // Cycle counter freezes while halted. A CYCLE_LO read latches the upper half of the same sample.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle  <= '0;
            shadow <= '0;
        end else begin
            if (!halt) cycle <= cycle + 64'd1;
            if (win_rd && off == OFF_CLO) shadow <= cycle[63:32];
        end
    end

    // Sticky halt. Only the first HALT write records the exit code.
    always_ff @(posedge clk) begin
        if (!reset) begin
            halt      <= 1'b0;
            exit_code <= '0;
        end else if (win_wr && off == OFF_HALT && !halt) begin
            halt      <= 1'b1;
            exit_code <= core_req_data[7:0];
        end
    end
endmodule

// File: tb/tb_mmio_sys_ctrl.sv
// Directed bench for mmio_sys_ctrl with NUM_CH=4 and FIFO_DEPTH=4.
// Stimulus is driven on negative edges, and outputs are sampled away from the rising edge.
module tb_mmio_sys_ctrl;
    localparam logic [31:0] W = 32'h0002_FFE0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_req_valid = 1'b0;
    logic [31:0] core_req_addr = '0;
    logic [3:0]  core_req_do_read = '0;
    logic [3:0]  core_req_do_write = '0;
    logic [31:0] core_req_data = '0;
    logic        core_rsp_valid;
    logic [31:0] core_rsp_data;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_do_read, mem_req_do_write;
    logic [31:0] mem_req_data;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic [3:0]  tx_valid;
    logic [31:0] tx_data;
    logic [3:0]  tx_ready = '0;
    logic        halt;
    logic [7:0]  exit_code;
    logic        halt_done;

    int n_cmp = 0;
    int n_err = 0;

    mmio_sys_ctrl #(.BASE_ADDR(W), .NUM_CH(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_addr(core_req_addr),
        .core_req_do_read(core_req_do_read), .core_req_do_write(core_req_do_write),
        .core_req_data(core_req_data),
        .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_do_read(mem_req_do_read), .mem_req_do_write(mem_req_do_write),
        .mem_req_data(mem_req_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .halt(halt), .exit_code(exit_code), .halt_done(halt_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // These tasks are entered just after a negedge and return just after a later negedge.
    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d, input logic [3:0] be);
        core_req_valid = 1'b1; core_req_addr = a; core_req_do_write = be;
        core_req_do_read = '0; core_req_data = {24'h0, d};
        #1 check("mreq_blocked_wr", mem_req_valid, 0);
        @(negedge clk);
        core_req_valid = 1'b0; core_req_do_write = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic v, output logic [31:0] d);
        core_req_valid = 1'b1; core_req_addr = a; core_req_do_read = 4'hF;
        core_req_do_write = '0;
        #1 check("mreq_blocked_rd", mem_req_valid, 0);
        @(negedge clk);
        core_req_valid = 1'b0; core_req_do_read = '0;
        v = core_rsp_valid; d = core_rsp_data;
    endtask

    logic        v;
    logic [31:0] d;

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_txv", tx_valid, 0);
        check("rst_halt", halt, 0);
        check("rst_exit", exit_code, 0);
        check("rst_hdone", halt_done, 0);
        check("rst_rspv", core_rsp_valid, 0);
        reset = 1'b1;

        // Read path: the counter is 0 at the reset edge and samples 100 at the 100th edge after it
        do_reset();
        repeat (100) @(negedge clk);
        rd(W + 32'h4, v, d);
        check("clo_v", v, 1);
        check("clo_d", d, 100);
        rd(W + 32'h8, v, d);
        check("chi_d", d, 0);
        rd(W + 32'h1C, v, d);
        check("halt_rd0", d, 0);
        @(negedge clk);
        check("rsp_idle", core_rsp_valid, 0);

        // Pass-through
        core_req_valid = 1'b1; core_req_addr = 32'h0001_0000; core_req_do_read = 4'hF;
        core_req_data = 32'h1234_5678;
        #1;
        check("pt_v", mem_req_valid, 1);
        check("pt_a", mem_req_addr, 32'h0001_0000);
        check("pt_rd", mem_req_do_read, 4'hF);
        check("pt_d", mem_req_data, 32'h1234_5678);
        @(negedge clk);
        core_req_valid = 1'b0; core_req_do_read = '0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        #1;
        check("pt_rspv", core_rsp_valid, 1);
        check("pt_rspd", core_rsp_data, 32'hDEAD_BEEF);
        @(negedge clk);
        mem_rsp_valid = 1'b0;

        // Legacy console write to ch0 with the consumer ready
        tx_ready = 4'b0001;
        wr(32'h0002_FFF8, 8'h41, 4'b0001);
        check("con_v", tx_valid[0], 1);
        check("con_d", tx_data[7:0], 8'h41);
        @(negedge clk);
        check("con_drained", tx_valid[0], 0);
        tx_ready = '0;

        // Multi-channel routing, then backpressure on ch2 only
        wr(32'h0002_FFF8, 8'h61, 4'h1);
        wr(32'h0002_FFF4, 8'h62, 4'h1);
        wr(32'h0002_FFF0, 8'h63, 4'h1);
        wr(32'h0002_FFEC, 8'h64, 4'h1);
        check("mc_v", tx_valid, 4'b1111);
        check("mc_d", tx_data, 32'h6463_6261);
        tx_ready = 4'b1011;
        @(negedge clk);
        tx_ready = '0;
        check("mc_bp_v", tx_valid, 4'b0100);
        check("mc_bp_d", tx_data[23:16], 8'h63);
        tx_ready = 4'hF;
        @(negedge clk);
        tx_ready = '0;
        check("mc_empty", tx_valid, 0);

        // Overflow on ch0: the fifth write is dropped
        for (int i = 0; i < 5; i++) wr(32'h0002_FFF8, 8'(8'h10 + i), 4'h1);
        rd(W, v, d);
        check("ovf_status", d, 32'h0001_0E01);
        tx_ready = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain", tx_data[7:0], 8'(8'h10 + i));
            @(negedge clk);
        end
        tx_ready = '0;
        check("ovf_empty", tx_valid[0], 0);

        // Fill ch3, then push with a pop in the same cycle: the push is accepted and no overflow is raised
        for (int i = 0; i < 4; i++) wr(32'h0002_FFEC, 8'(8'h30 + i), 4'h1);
        tx_ready = 4'b1000;
        wr(32'h0002_FFEC, 8'h34, 4'h1);
        tx_ready = '0;
        rd(W, v, d);
        check("pp_status", d, 32'h0001_0708);
        tx_ready = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            check("pp_drain", tx_data[31:24], 8'(8'h31 + i));
            @(negedge clk);
        end
        tx_ready = '0;
        check("pp_empty", tx_valid[3], 0);

        // Legacy halt: the counter samples 5 at the halt edge, takes its last increment to 6, then freezes
        do_reset();
        repeat (5) @(negedge clk);
        wr(32'h0002_FFFD, 8'h05, 4'b0010);
        check("halt_set", halt, 1);
        check("halt_code", exit_code, 8'h05);
        check("halt_done", halt_done, 1);
        repeat (10) @(negedge clk);
        rd(W + 32'h4, v, d);
        check("halt_frozen", d, 6);
        wr(32'h0002_FFFD, 8'h77, 4'b0001);
        check("halt_sticky", exit_code, 8'h05);
        wr(32'h0002_FFF4, 8'h55, 4'h1);
        check("halt_push", tx_valid[1], 1);
        check("halt_notdone", halt_done, 0);

        // Reset mid-operation with ch0 half full and halt set
        wr(32'h0002_FFF8, 8'h01, 4'h1);
        wr(32'h0002_FFF8, 8'h02, 4'h1);
        do_reset();
        check("mr_txv", tx_valid, 0);
        check("mr_halt", halt, 0);
        check("mr_exit", exit_code, 0);
        check("mr_hdone", halt_done, 0);
        check("mr_rspv", core_rsp_valid, 0);
        rd(W + 32'h4, v, d);
        check("mr_cnt", d, 0);
        rd(W, v, d);
        check("mr_status", d, 32'h0000_0F00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
